// File: rtl/sd_pkg.sv
// Shared definitions for the SD command sequencer: FSM states, SPI register
// map, frame framing constants and the command-frame byte selector.
package sd_pkg;

    // Sequencer states, in the order a command normally walks through them
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG,
        ST_TX,
        ST_TXW,
        ST_SRCH,
        ST_SRCHW,
        ST_RDR1,
        ST_RX,
        ST_RXW,
        ST_RDRX,
        ST_END,
        ST_ENDW,
        ST_DONE
    } state_t;

    // SPI block register map
    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_SRCH    = 3'd1;
    localparam logic [2:0] REG_READY   = 3'd2;
    localparam logic [2:0] REG_TIMEOUT = 3'd7;

    // Command frame start bits ("01") and trailing stop bit
    localparam logic [1:0] FRAME_START = 2'b01;
    localparam logic       FRAME_STOP  = 1'b1;

    // Byte clocked out while only receiving
    localparam logic [7:0] FILL_BYTE = 8'hFF;

    // Index of the last frame byte and of the last trailing response byte
    localparam logic [2:0] LAST_FRAME_BYTE = 3'd5;
    localparam logic [1:0] LAST_RESP_BYTE  = 2'd3;

    // Select byte i (0..5) of the six-byte command frame
    function automatic logic [7:0] frame_byte(
        input logic [2:0]  i,
        input logic [5:0]  index,
        input logic [31:0] arg,
        input logic [6:0]  crc
    );
        logic [7:0] b;
        case (i)
            3'd0:    b = {FRAME_START, index};
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
            3'd5:    b = {crc, FRAME_STOP};
            default: b = FILL_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_cmd_seq.sv
// SD command sequencer: drives an SPI register block through one complete
// SD command (timeout setup, 6-byte frame, R1 search, optional 4 trailing
// bytes, transaction close and ready poll). Strobes, address and write data
// are registered on entry to the state that performs the access, so each
// access state owns exactly the cycle in which its strobe is high.
module sd_cmd_seq
    import sd_pkg::*;
#(
    parameter logic [1:0] SEL     = 2'd0,
    parameter logic [7:0] TIMEOUT = 8'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic        cmd_long,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic [7:0]  cmd_r1,
    output logic [31:0] cmd_resp,
    output logic [2:0]  spi_reg_addr,
    output logic [7:0]  spi_reg_wdata,
    output logic [1:0]  spi_reg_sel,
    output logic        spi_reg_read,
    output logic        spi_reg_write,
    input  logic [7:0]  spi_reg_rdata,
    input  logic        spi_interrupt
);

    state_t      state;
    logic [5:0]  lat_index;
    logic [31:0] lat_arg;
    logic [6:0]  lat_crc;
    logic        lat_long;
    logic [2:0]  byte_idx;
    logic [1:0]  rx_cnt;
    logic        wait_first;
    logic        wait_done;

    assign spi_reg_sel = SEL;

    // A wait state completes on the first interrupt seen after its first
    // cycle; the first cycle may still show the previous byte's flag.
    assign wait_done = !wait_first && spi_interrupt;

    // Command sequencer FSM with registered strobes and results
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cmd_busy      <= 1'b0;
            cmd_done      <= 1'b0;
            cmd_err       <= 1'b0;
            cmd_r1        <= 8'h00;
            cmd_resp      <= 32'h0;
            spi_reg_addr  <= 3'd0;
            spi_reg_wdata <= 8'h00;
            spi_reg_read  <= 1'b0;
            spi_reg_write <= 1'b0;
            lat_index     <= 6'd0;
            lat_arg       <= 32'h0;
            lat_crc       <= 7'd0;
            lat_long      <= 1'b0;
            byte_idx      <= 3'd0;
            rx_cnt        <= 2'd0;
            wait_first    <= 1'b0;
        end else begin
            spi_reg_read  <= 1'b0;
            spi_reg_write <= 1'b0;
            cmd_done      <= 1'b0;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (cmd_start) begin
                        lat_index     <= cmd_index;
                        lat_arg       <= cmd_arg;
                        lat_crc       <= cmd_crc;
                        lat_long      <= cmd_long;
                        cmd_r1        <= 8'h00;
                        cmd_resp      <= 32'h0;
                        cmd_err       <= 1'b0;
                        cmd_busy      <= 1'b1;
                        spi_reg_write <= 1'b1;
                        spi_reg_addr  <= REG_TIMEOUT;
                        spi_reg_wdata <= TIMEOUT;
                        state         <= ST_CFG;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_CFG: begin
                    byte_idx      <= 3'd0;
                    spi_reg_write <= 1'b1;
                    spi_reg_addr  <= REG_DATA;
                    spi_reg_wdata <= frame_byte(3'd0, lat_index, lat_arg, lat_crc);
                    state         <= ST_TX;
                end

                ST_TX: begin
                    wait_first <= 1'b1;
                    state      <= ST_TXW;
                end

                ST_TXW: begin
                    wait_first <= 1'b0;
                    if (wait_done) begin
                        spi_reg_write <= 1'b1;
                        if (byte_idx != LAST_FRAME_BYTE) begin
                            byte_idx      <= byte_idx + 3'd1;
                            spi_reg_addr  <= REG_DATA;
                            spi_reg_wdata <= frame_byte(byte_idx + 3'd1, lat_index,
                                                        lat_arg, lat_crc);
                            state         <= ST_TX;
                        end else begin
                            spi_reg_addr  <= REG_SRCH;
                            spi_reg_wdata <= FILL_BYTE;
                            state         <= ST_SRCH;
                        end
                    end
                end

                ST_SRCH: begin
                    wait_first <= 1'b1;
                    state      <= ST_SRCHW;
                end

                ST_SRCHW: begin
                    wait_first <= 1'b0;
                    if (wait_done) begin
                        spi_reg_read <= 1'b1;
                        spi_reg_addr <= REG_SRCH;
                        state        <= ST_RDR1;
                    end
                end

                // R1 bit7 set means the search ran out before a response
                ST_RDR1: begin
                    cmd_r1 <= spi_reg_rdata;
                    if (spi_reg_rdata[7]) begin
                        cmd_err      <= 1'b1;
                        spi_reg_read <= 1'b1;
                        spi_reg_addr <= REG_DATA;
                        state        <= ST_END;
                    end else if (lat_long) begin
                        rx_cnt        <= 2'd0;
                        spi_reg_write <= 1'b1;
                        spi_reg_addr  <= REG_DATA;
                        spi_reg_wdata <= FILL_BYTE;
                        state         <= ST_RX;
                    end else begin
                        spi_reg_read <= 1'b1;
                        spi_reg_addr <= REG_DATA;
                        state        <= ST_END;
                    end
                end

                ST_RX: begin
                    wait_first <= 1'b1;
                    state      <= ST_RXW;
                end

                ST_RXW: begin
                    wait_first <= 1'b0;
                    if (wait_done) begin
                        spi_reg_read <= 1'b1;
                        spi_reg_addr <= REG_SRCH;
                        state        <= ST_RDRX;
                    end
                end

                ST_RDRX: begin
                    cmd_resp <= {cmd_resp[23:0], spi_reg_rdata};
                    if (rx_cnt != LAST_RESP_BYTE) begin
                        rx_cnt        <= rx_cnt + 2'd1;
                        spi_reg_write <= 1'b1;
                        spi_reg_addr  <= REG_DATA;
                        spi_reg_wdata <= FILL_BYTE;
                        state         <= ST_RX;
                    end else begin
                        spi_reg_read <= 1'b1;
                        spi_reg_addr <= REG_DATA;
                        state        <= ST_END;
                    end
                end

                // The addr-0 read in END closes the transaction; start polling
                ST_END: begin
                    spi_reg_read <= 1'b1;
                    spi_reg_addr <= REG_READY;
                    state        <= ST_ENDW;
                end

                ST_ENDW: begin
                    if (spi_reg_rdata[0]) begin
                        cmd_done <= 1'b1;
                        cmd_busy <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        spi_reg_read <= 1'b1;
                        spi_reg_addr <= REG_READY;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    cmd_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sd_cmd_seq.md
SD_CMD_SEQ -- requirements
Module: sd_cmd_seq

Interface
REQ-001 Parameter SEL, default 2'd0: spi device select (reg_sel value) used for every SPI register access.
REQ-002 Parameter TIMEOUT, default 8'd16: value written to SPI register 7 (search timeout, in bytes) before each command.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_start  input  1  one-cycle request to issue a command; honoured only when cmd_busy=0.
REQ-006 cmd_index  input  6  SD command index.
REQ-007 cmd_arg  input  32  command argument, sent MSB first.
REQ-008 cmd_crc  input  7  CRC7 for the frame.
REQ-009 cmd_long  input  1  1: R1 plus 4 trailing response bytes (R3/R7); 0: R1 only.
REQ-010 cmd_busy  output  1  sequence in progress.
REQ-011 cmd_done  output  1  one-cycle pulse at sequence end.
REQ-012 cmd_err  output  1  R1 bit7 set (no response before timeout); valid with cmd_done, held until next start.
REQ-013 cmd_r1  output  8  captured R1 byte.
REQ-014 cmd_resp  output  32  trailing bytes, first received in [31:24]; 0 when cmd_long=0.
REQ-015 spi_reg_addr  output  3  SPI register address.
REQ-016 spi_reg_wdata  output  8  SPI register write data.
REQ-017 spi_reg_sel  output  2  constant SEL.
REQ-018 spi_reg_read  output  1  SPI register read strobe.
REQ-019 spi_reg_write  output  1  SPI register write strobe.
REQ-020 spi_reg_rdata  input  8  combinational SPI read data, valid in the same cycle as spi_reg_read.
REQ-021 spi_interrupt  input  1  SPI byte-complete flag; clears one cycle after an accepted write.

Function
REQ-022 Asserts at most one of spi_reg_read/spi_reg_write per cycle; both are single-cycle pulses.
REQ-023 States: IDLE, CFG, TX, TXW, SRCH, SRCHW, RDR1, RX, RXW, RDRX, END, ENDW, DONE.
REQ-024 IDLE + cmd_start: latch inputs, clear r1/resp/err, busy=1 next cycle, go to CFG.
REQ-025 CFG: write addr 7 = TIMEOUT, go to TX with byte index 0.
REQ-026 Frame bytes 0..5: {2'b01,cmd_index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {cmd_crc,1'b1}.
REQ-027 TX: write addr 0 with the current frame byte, then TXW; byte 0 opens the transaction (CS low), bytes 1-5 are non-searching continuation writes.
REQ-028 Every wait state ignores spi_interrupt in its first cycle and advances on the first later cycle where spi_interrupt=1.
REQ-029 TXW done: byte index <5 -> increment, TX; index 5 -> SRCH.
REQ-030 SRCH: write addr 1 with 8'hFF (searching transfer), then SRCHW; SRCHW done -> RDR1.
REQ-031 RDR1: read addr 1, capture rdata into cmd_r1; bit7=1 -> err=1, END; else cmd_long -> RX with count 0, else END.
REQ-032 RX: write addr 0 with 8'hFF, then RXW; RXW done -> RDRX.
REQ-033 RDRX: read addr 1, shift rdata into cmd_resp LSB end; count <3 -> increment, RX; count 3 -> END.
REQ-034 END: read addr 0 (closes transaction), then ENDW.
REQ-035 ENDW: read addr 2 each cycle; advance to DONE when rdata[0]=1.
REQ-036 DONE: cmd_done=1 for one cycle, busy=0, return to IDLE.
REQ-037 cmd_start while busy is ignored, with no effect on latched inputs.
REQ-038 Latency with zero-delay SPI model: exactly 14+2*(bytes) overhead cycles; the bench checks the ordering of accesses, not absolute cycle counts.

Reset
REQ-039 Reset forces IDLE; cmd_busy, cmd_done, cmd_err, spi_reg_read, spi_reg_write = 0; cmd_r1, cmd_resp, spi_reg_addr, spi_reg_wdata = 0.
REQ-040 Reset mid-sequence abandons the sequence with no further SPI accesses; the SPI block is reset by the same reset.

Structure
REQ-041 Shared package sd_pkg holds the state enum, SPI register address constants (DATA=0, SRCH=1, READY=2, TIMEOUT=7) and the frame start/stop bit constants.
REQ-042 Single flat module; no sub-modules.
REQ-043 The host configuration path to SPI registers 4/5 is muxed outside this block and is selected when cmd_busy=0.

Verification
REQ-044 CMD0, arg 0, crc 0x4A; model answers 0x01 after 3 bytes of 0xFF -> writes 40 00 00 00 00 95, cmd_r1=0x01, err=0, resp=0, one done pulse.
REQ-045 CMD8, long, arg 0x1AA, crc 0x43; R1=0x01 then 00 00 01 AA -> frame 48 00 00 01 AA 87, cmd_resp=0x000001AA.
REQ-046 MISO held high -> search times out, cmd_r1=0xFF, err=1, no RX writes, addr 0 read issued, CS high before done.
REQ-047 cmd_start pulsed during TXW with different index -> ignored; frame and results match the first command.
REQ-048 Reset asserted during byte 3 -> outputs at reset values next cycle; a following CMD0 completes normally.
